// File: rtl/movingsum_decoder_if.sv
// Stream interface for the moving-sum decoder: sum samples in, reconstructed samples out.
// The decoder takes the slave modport and the upstream/downstream side takes the master modport.
interface movingsum_decoder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y_i;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] x_o;

   modport master (
      output in_valid, y_i, out_ready,
      input  in_ready, out_valid, x_o
   );

   modport slave (
      input  in_valid, y_i, out_ready,
      output in_ready, out_valid, x_o
   );
endinterface

// File: rtl/movingsum_decoder.sv
// Inverse of a TAPS-tap wrapping moving-sum filter: x[n] = y[n] - y[n-1] + x[n-TAPS].
// Define MOVINGSUM_DECODER_OUTREG_EN to add a second output register stage (2-cycle latency).
module movingsum_decoder #(
   parameter int WIDTH = 8,
   parameter int TAPS  = 4
) (
   input  logic                system1000,
   input  logic                system1000_rst,
   input  logic                sync_i,
   movingsum_decoder_if.slave  bus,
   output logic                primed_o
);
   localparam int CW = $clog2(TAPS + 1);

   logic [WIDTH-1:0] y_prev_q, y_prev_d;
   logic [WIDTH-1:0] hist_q [TAPS];
   logic [WIDTH-1:0] hist_d [TAPS];
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic             primed_q, primed_d;

   logic             accept;
   logic             in_ready;
   logic [WIDTH-1:0] y_prev_eff;
   logic [WIDTH-1:0] tap_eff;
   logic [CW-1:0]    cnt_eff;
   logic [WIDTH-1:0] x_new;

   assign accept = bus.in_valid && in_ready;

   // A sync on the same edge as an accept decodes against cleared history (n=0).
   assign y_prev_eff = sync_i ? '0 : y_prev_q;
   assign tap_eff    = sync_i ? '0 : hist_q[TAPS-1];
   assign cnt_eff    = sync_i ? '0 : cnt_q;
   assign x_new      = bus.y_i - y_prev_eff + tap_eff;

   always_comb begin
      y_prev_d = y_prev_q;
      cnt_d    = cnt_q;
      for (int k = 0; k < TAPS; k++) begin
         hist_d[k] = hist_q[k];
      end
      if (sync_i) begin
         y_prev_d = '0;
         cnt_d    = '0;
         for (int k = 0; k < TAPS; k++) begin
            hist_d[k] = '0;
         end
      end
      if (accept) begin
         y_prev_d  = bus.y_i;
         hist_d[0] = x_new;
         for (int k = 1; k < TAPS; k++) begin
            hist_d[k] = sync_i ? '0 : hist_q[k-1];
         end
         cnt_d = (cnt_eff == CW'(TAPS)) ? cnt_eff : cnt_eff + 1'b1;
      end
   end

   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         y_prev_q <= '0;
         cnt_q    <= '0;
         for (int k = 0; k < TAPS; k++) begin
            hist_q[k] <= '0;
         end
      end else begin
         y_prev_q <= y_prev_d;
         cnt_q    <= cnt_d;
         for (int k = 0; k < TAPS; k++) begin
            hist_q[k] <= hist_d[k];
         end
      end
   end

`ifdef MOVINGSUM_DECODER_OUTREG_EN
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_x_q, s1_x_d;
   logic             s1_primed_q, s1_primed_d;
   logic             s2_free;

   assign s2_free  = !out_valid_q || bus.out_ready;
   assign in_ready = !s1_valid_q || s2_free;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_x_d      = s1_x_q;
      s1_primed_d = s1_primed_q;
      out_valid_d = out_valid_q;
      x_d         = x_q;
      primed_d    = primed_q;
      if (s2_free) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            x_d      = s1_x_q;
            primed_d = s1_primed_q;
         end
      end
      if (accept) begin
         s1_valid_d  = 1'b1;
         s1_x_d      = x_new;
         s1_primed_d = (cnt_d == CW'(TAPS));
      end else begin
         if (s2_free) begin
            s1_valid_d = 1'b0;
         end
         if (sync_i) begin
            s1_primed_d = 1'b0;
         end
      end
   end

   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         s1_valid_q  <= 1'b0;
         s1_x_q      <= '0;
         s1_primed_q <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_x_q      <= s1_x_d;
         s1_primed_q <= s1_primed_d;
      end
   end
`else
   assign in_ready = !out_valid_q || bus.out_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      x_d         = x_q;
      primed_d    = primed_q;
      if (accept) begin
         out_valid_d = 1'b1;
         x_d         = x_new;
         primed_d    = (cnt_d == CW'(TAPS));
      end else begin
         if (bus.out_ready) begin
            out_valid_d = 1'b0;
         end
         if (sync_i) begin
            primed_d = 1'b0;
         end
      end
   end
`endif

   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         out_valid_q <= 1'b0;
         x_q         <= '0;
         primed_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         x_q         <= x_d;
         primed_q    <= primed_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.x_o       = x_q;
   assign primed_o      = primed_q;
endmodule

// File: tb/tb_movingsum_decoder.sv
// Directed and loopback checks of movingsum_decoder in its default single-register build.
module tb_movingsum_decoder;
   localparam int N_LOOP = 1000;

   logic system1000;
   logic system1000_rst;
   logic sync_i;
   logic primed_o;

   int checks   = 0;
   int failures = 0;

   movingsum_decoder_if #(.WIDTH(8)) bus ();

   movingsum_decoder #(.WIDTH(8), .TAPS(4)) dut (
      .system1000     (system1000),
      .system1000_rst (system1000_rst),
      .sync_i         (sync_i),
      .bus            (bus),
      .primed_o       (primed_o)
   );

   initial begin
      system1000 = 1'b0;
      forever #5 system1000 = ~system1000;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs, clock it, and leave time 1 unit after the edge.
   task automatic step(input logic v, input logic [7:0] y, input logic s, input logic r);
      bus.in_valid  = v;
      bus.y_i       = y;
      sync_i        = s;
      bus.out_ready = r;
      @(posedge system1000);
      #1;
      $display("t=%0t in_valid=%0b y=%0d sync=%0b out_ready=%0b -> out_valid=%0b x=%0d primed=%0b",
               $time, v, y, s, r, bus.out_valid, bus.x_o, primed_o);
   endtask

   logic [7:0] orig [N_LOOP];

   function automatic logic [7:0] enc(input int n);
      logic [7:0] acc;
      acc = 8'd0;
      for (int k = 0; k < 4; k++) begin
         if (n - k >= 0) acc = acc + orig[n-k];
      end
      return acc;
   endfunction

   logic [7:0] basic_y [6] = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd14, 8'd18};
   logic [7:0] wrap_y  [5] = '{8'd100, 8'd200, 8'd44, 8'd144, 8'd144};

   initial begin
      int idx;
      int got;
      system1000_rst = 1'b1;
      sync_i         = 1'b0;
      bus.in_valid   = 1'b0;
      bus.y_i        = 8'd0;
      bus.out_ready  = 1'b1;
      #12;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_x", 32'(bus.x_o), 32'd0);
      check("rst_primed", 32'(primed_o), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      #1 system1000_rst = 1'b0;

      // Basic decode with free-running output
      for (int i = 0; i < 6; i++) begin
         step(1'b1, basic_y[i], 1'b0, 1'b1);
         check("basic_valid", 32'(bus.out_valid), 32'd1);
         check("basic_x", 32'(bus.x_o), 32'(i + 1));
         check("basic_primed", 32'(primed_o), (i >= 3) ? 32'd1 : 32'd0);
      end
      step(1'b0, 8'd0, 1'b0, 1'b1);
      check("drain_valid", 32'(bus.out_valid), 32'd0);

      // Wrap-around: all samples decode to 100
      for (int i = 0; i < 5; i++) begin
         step(1'b1, wrap_y[i], (i == 0), 1'b1);
         check("wrap_x", 32'(bus.x_o), 32'd100);
      end
      step(1'b0, 8'd0, 1'b0, 1'b1);

      // Backpressure: y=3 must wait while x=1 is held
      step(1'b1, 8'd1, 1'b1, 1'b0);
      check("bp_first_x", 32'(bus.x_o), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'd3, 1'b0, 1'b0);
         check("bp_hold_x", 32'(bus.x_o), 32'd1);
         check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      step(1'b1, 8'd3, 1'b0, 1'b1);
      check("bp_resume_x", 32'(bus.x_o), 32'd2);
      step(1'b1, 8'd6, 1'b0, 1'b1);
      check("bp_next_x", 32'(bus.x_o), 32'd3);
      step(1'b0, 8'd0, 1'b0, 1'b1);

      // Sync mid-stream after the decoder is primed
      step(1'b1, 8'd1, 1'b1, 1'b1);
      step(1'b1, 8'd3, 1'b0, 1'b1);
      step(1'b1, 8'd6, 1'b0, 1'b1);
      step(1'b1, 8'd10, 1'b0, 1'b1);
      check("pre_sync_primed", 32'(primed_o), 32'd1);
      step(1'b1, 8'd7, 1'b1, 1'b1);
      check("sync_x", 32'(bus.x_o), 32'd7);
      check("sync_primed", 32'(primed_o), 32'd0);
      step(1'b1, 8'd15, 1'b0, 1'b1);
      check("post_sync_x", 32'(bus.x_o), 32'd8);
      step(1'b1, 8'd24, 1'b0, 1'b1);
      check("post_sync_x2", 32'(bus.x_o), 32'd9);
      step(1'b1, 8'd34, 1'b0, 1'b1);
      check("post_sync_x3", 32'(bus.x_o), 32'd10);
      check("post_sync_primed", 32'(primed_o), 32'd1);

      // Async reset between edges discards the held output
      step(1'b0, 8'd0, 1'b0, 1'b0);
      check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      #2 system1000_rst = 1'b1;
      #1;
      check("arst_valid", 32'(bus.out_valid), 32'd0);
      check("arst_x", 32'(bus.x_o), 32'd0);
      check("arst_primed", 32'(primed_o), 32'd0);
      #2 system1000_rst = 1'b0;
      step(1'b1, 8'd5, 1'b0, 1'b1);
      check("arst_resume_x", 32'(bus.x_o), 32'd5);
      check("arst_resume_valid", 32'(bus.out_valid), 32'd1);
      step(1'b0, 8'd0, 1'b0, 1'b1);
      check("pre_loop_valid", 32'(bus.out_valid), 32'd0);

      // Loopback through a bench-side moving-sum encoder with random gaps
      for (int i = 0; i < N_LOOP; i++) begin
         orig[i] = 8'($urandom);
      end
      idx = 0;
      got = 0;
      for (int c = 0; c < 20000 && got < N_LOOP; c++) begin
         bus.in_valid  = (idx < N_LOOP) && ($urandom_range(0, 3) != 0);
         bus.y_i       = (idx < N_LOOP) ? enc(idx) : 8'd0;
         sync_i        = (idx == 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            $display("loop out[%0d] x=%0d", got, bus.x_o);
            check("loop_x", 32'(bus.x_o), 32'(orig[got]));
            got++;
         end
         if (bus.in_valid && bus.in_ready) idx++;
         @(posedge system1000);
         #1;
      end
      check("loop_count", 32'(got), 32'(N_LOOP));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/movingsum_decoder.md
Name: movingsum_decoder

Overview:
- Inverse of the 4-tap moving-sum filter: takes the stream y[n] = x[n]+x[n-1]+x[n-2]+x[n-3] (mod 2^WIDTH) and reconstructs the original samples x[n].
- Sits on the receive side of the moving-sum link. It is paired with the filter so that raw data can be recovered for loopback test and for downstream blocks that need un-averaged samples.
- Adds a valid/ready handshake, a registered output, and a resynchronisation input.

Parameters:
- WIDTH, 8: sample and sum width, two's-complement signed.
- TAPS, 4: window length of the paired moving-sum filter (>=2).

Ports:
- system1000  input  1  clock; all logic is on the rising edge.
- system1000_rst  input  1  asynchronous reset, active-high.
- sync_i  input  1  synchronous restart: clears history, marks the next accepted sample as n=0.
- in_valid  input  1  y_i is valid this cycle.
- in_ready  output  1  block can accept y_i this cycle.
- y_i  input  WIDTH  moving-sum sample (signed).
- out_valid  output  1  x_o holds a decoded sample.
- out_ready  input  1  downstream accepts x_o this cycle.
- x_o  output  WIDTH  reconstructed sample (signed).
- primed_o  output  1  high once TAPS samples have been accepted since reset/sync.

Behaviour:
- Reset (async, system1000_rst=1):
  - out_valid=0, x_o=0, primed_o=0.
  - y_prev=0, all TAPS history entries=0, sample counter=0.
  - Effect takes hold immediately, independent of the clock. Reset asserted mid-stream discards any held output.
- Accept and handshake:
  - An input is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational, single output slot, no bubble under full throughput).
  - State (history, y_prev, counter) advances only on an accepted input.
- Decode on accept:
  - x[n] = y[n] - y_prev + hist[TAPS-1], where hist[k] = x[n-1-k].
  - All arithmetic is modulo 2^WIDTH with no saturation; wrap-around is required for exact inversion of the wrapping encoder.
  - Update: y_prev <= y[n]; history shifts, with hist[0] <= x[n] and hist[k] <= hist[k-1].
- Latency and output hold:
  - Latency is 1 cycle: x_o and out_valid are registered on the accept edge.
  - x_o holds stable while out_valid && !out_ready.
  - out_valid clears on an output handshake with no simultaneous accept.
  - On a simultaneous output handshake and input accept, out_valid stays 1 and x_o takes the new value.
- primed_o:
  - A saturating counter increments per accept, capped at TAPS.
  - primed_o=1 when the counter reaches TAPS; this is registered alongside the output.
- sync_i, sampled on the clock edge:
  - y_prev, history and counter clear; primed_o=0.
  - If in_valid is also accepted on that edge, the sample is decoded as n=0, i.e. x = y_i, and history is loaded from the cleared state.
  - An already-held x_o and its out_valid are unaffected.
- Stalls: with in_valid=0, or in_ready=0 with in_valid=1, no state changes.

Optional Feature:
- Macro: MOVINGSUM_DECODER_OUTREG_EN.
- Defined:
  - Adds a second output register stage, giving a 2-cycle latency.
  - The handshake becomes a 2-entry pipeline: in_ready = !stage2_full || out_ready || !stage1_full.
  - Ordering and values are identical to the undefined case.
  - primed_o is delayed to stay aligned with x_o.
- Undefined: the single-register, 1-cycle path described above.

Test Plan:
- Basic decode, out_ready=1: y = 1,3,6,10,14,18 every cycle -> x_o = 1,2,3,4,5,6, each 1 cycle after its input. primed_o rises with the 4th output.
- Wrap-around, WIDTH=8: y = 100,-56,44,-112,-112 -> x_o = 100,100,100,100,100 with no saturation artefacts.
- Backpressure: hold out_ready=0 for 3 cycles while out_valid=1 -> x_o stable, in_ready=0, no input consumed. Releasing out_ready resumes with no lost or duplicated samples.
- Sync mid-stream: after 1,3,6 assert sync_i with y=7 -> x_o=7 and primed_o=0. Then y=15 -> x_o=8.
- Async reset mid-stream: assert system1000_rst between clock edges -> out_valid, x_o and primed_o go to 0 before the next edge. Resume: y=5 -> x_o=5.
- End-to-end loopback: random 1000 signed samples through the moving-sum filter into this block -> decoded stream equals the original, including under random in_valid/out_ready gaps.
